// File: rtl/mem_responder_if.sv
// mem_responder_if -- request/response bundle between the CPU's memory
// ports and mem_responder.
//   imem_addr/imem_rmask            : instruction read request (rmask != 0 requests)
//   imem_rdata/imem_resp            : instruction read word, one-cycle completion pulse
//   dmem_addr/dmem_rmask/dmem_wmask : data request (either mask != 0 requests)
//   dmem_wdata                      : write data, byte lanes aligned to the word
//   dmem_rdata/dmem_resp            : data read word, one-cycle completion pulse
// master = initiator (CPU / testbench), slave = mem_responder.
interface mem_responder_if;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;

    modport master (
        output imem_addr, imem_rmask, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        input  imem_rdata, imem_resp, dmem_rdata, dmem_resp
    );

    modport slave (
        input  imem_addr, imem_rmask, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        output imem_rdata, imem_resp, dmem_rdata, dmem_resp
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder -- multi-cycle memory model serving an imem and a dmem port
// from one shared word array, each port with its own fixed response latency
// and a single outstanding request.
//   clk : clock
//   rst : synchronous active-high reset (array contents are not reset)
//   bus : mem_responder_if.slave (request inputs, rdata/resp outputs)
// Each port runs IDLE -> BUSY -> RESP -> IDLE. A request is accepted on the
// edge it is seen in IDLE; reads sample the word and writes commit on that
// edge, and resp pulses LATENCY cycles later.
module mem_responder #(
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned IMEM_LATENCY = 2,
    parameter int unsigned DMEM_LATENCY = 3
) (
    input logic              clk,
    input logic              rst,
    mem_responder_if.slave   bus
);
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned MAX_LAT = (IMEM_LATENCY > DMEM_LATENCY) ? IMEM_LATENCY : DMEM_LATENCY;
    localparam int unsigned CW      = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_e;

    logic [31:0] mem [DEPTH];

    logic [AW-1:0] iidx, didx;
    logic          ireq, dreq;
    logic [31:0]   iword, dword;
    logic          d_accept;

    state_e        istate_q, istate_d, dstate_q, dstate_d;
    logic [CW-1:0] icnt_q, icnt_d, dcnt_q, dcnt_d;
    logic [31:0]   ihold_q, ihold_d, dhold_q, dhold_d;
    logic [31:0]   irdata_q, irdata_d, drdata_q, drdata_d;

    // Address bits outside the word index are don't-care (addresses wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.imem_addr[31:AW+2], bus.imem_addr[1:0],
                                bus.dmem_addr[31:AW+2], bus.dmem_addr[1:0]};

    assign iidx  = bus.imem_addr[AW+1:2];
    assign didx  = bus.dmem_addr[AW+1:2];
    assign ireq  = (bus.imem_rmask != 4'h0);
    assign dreq  = (bus.dmem_rmask != 4'h0) || (bus.dmem_wmask != 4'h0);
    // Array reads see the pre-edge contents, so a same-edge write is not
    // visible to either port's read.
    assign iword = mem[iidx];
    assign dword = (bus.dmem_rmask != 4'h0) ? mem[didx] : '0;

    assign d_accept = (dstate_q == ST_IDLE) && dreq && !rst;

    // Array: no reset; writes gated by rst so a request seen under reset
    // never commits.
    always_ff @(posedge clk) begin
        if (d_accept) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (bus.dmem_wmask[b]) begin
                    mem[didx][8*b +: 8] <= bus.dmem_wdata[8*b +: 8];
                end
            end
        end
    end

    // ---------------- imem port ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            istate_q <= ST_IDLE;
            icnt_q   <= '0;
            ihold_q  <= '0;
            irdata_q <= '0;
        end else begin
            istate_q <= istate_d;
            icnt_q   <= icnt_d;
            ihold_q  <= ihold_d;
            irdata_q <= irdata_d;
        end
    end

    always_comb begin
        istate_d = istate_q;
        icnt_d   = icnt_q;
        unique case (istate_q)
            ST_IDLE: begin
                if (ireq) begin
                    icnt_d   = CW'(IMEM_LATENCY - 1);
                    istate_d = (IMEM_LATENCY == 1) ? ST_RESP : ST_BUSY;
                end
            end
            ST_BUSY: begin
                icnt_d = icnt_q - CW'(1);
                if (icnt_q == CW'(1)) istate_d = ST_RESP;
            end
            ST_RESP: istate_d = ST_IDLE;
            default: istate_d = ST_IDLE;
        endcase
    end

    // rdata is loaded only on entry to RESP so it holds between responses;
    // with latency 1 the entry edge is also the acceptance edge.
    always_comb begin
        ihold_d  = ihold_q;
        irdata_d = irdata_q;
        if (istate_q == ST_IDLE && ireq) ihold_d = iword;
        if (istate_q != ST_RESP && istate_d == ST_RESP)
            irdata_d = (istate_q == ST_IDLE) ? iword : ihold_q;
    end

    assign bus.imem_resp  = (istate_q == ST_RESP);
    assign bus.imem_rdata = irdata_q;

    // ---------------- dmem port ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            dstate_q <= ST_IDLE;
            dcnt_q   <= '0;
            dhold_q  <= '0;
            drdata_q <= '0;
        end else begin
            dstate_q <= dstate_d;
            dcnt_q   <= dcnt_d;
            dhold_q  <= dhold_d;
            drdata_q <= drdata_d;
        end
    end

    always_comb begin
        dstate_d = dstate_q;
        dcnt_d   = dcnt_q;
        unique case (dstate_q)
            ST_IDLE: begin
                if (dreq) begin
                    dcnt_d   = CW'(DMEM_LATENCY - 1);
                    dstate_d = (DMEM_LATENCY == 1) ? ST_RESP : ST_BUSY;
                end
            end
            ST_BUSY: begin
                dcnt_d = dcnt_q - CW'(1);
                if (dcnt_q == CW'(1)) dstate_d = ST_RESP;
            end
            ST_RESP: dstate_d = ST_IDLE;
            default: dstate_d = ST_IDLE;
        endcase
    end

    // Write-only requests return 0 (dword is 0 when rmask is clear).
    always_comb begin
        dhold_d  = dhold_q;
        drdata_d = drdata_q;
        if (dstate_q == ST_IDLE && dreq) dhold_d = dword;
        if (dstate_q != ST_RESP && dstate_d == ST_RESP)
            drdata_d = (dstate_q == ST_IDLE) ? dword : dhold_q;
    end

    assign bus.dmem_resp  = (dstate_q == ST_RESP);
    assign bus.dmem_rdata = drdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder -- directed self-checking bench for mem_responder with
// imem latency 2, dmem latency 3, DEPTH 1024.
module tb_mem_responder;
    localparam int unsigned ILAT = 2;
    localparam int unsigned DLAT = 3;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    mem_responder_if bus ();

    mem_responder #(
        .DEPTH        (1024),
        .IMEM_LATENCY (ILAT),
        .DMEM_LATENCY (DLAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit
    // after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.imem_addr  = '0;
        bus.imem_rmask = '0;
        bus.dmem_addr  = '0;
        bus.dmem_rmask = '0;
        bus.dmem_wmask = '0;
        bus.dmem_wdata = '0;
    endtask

    // Full dmem transaction: request held until resp, resp checked low
    // before C+DLAT, high at C+DLAT with rdata, low again the cycle after.
    task automatic dmem_op(input string tag, input logic [31:0] addr, input logic [3:0] rm,
                           input logic [3:0] wm, input logic [31:0] wd, input logic [31:0] exp);
        bus.dmem_addr  = addr;
        bus.dmem_rmask = rm;
        bus.dmem_wmask = wm;
        bus.dmem_wdata = wd;
        for (int k = 1; k <= int'(DLAT); k++) begin
            tick();
            if (k < int'(DLAT)) chk({tag, "_early"}, 32'(bus.dmem_resp), 32'd0);
        end
        chk({tag, "_resp"}, 32'(bus.dmem_resp), 32'd1);
        chk({tag, "_rdata"}, bus.dmem_rdata, exp);
        bus.dmem_rmask = '0;
        bus.dmem_wmask = '0;
        tick();
        chk({tag, "_pulse"}, 32'(bus.dmem_resp), 32'd0);
    endtask

    task automatic imem_op(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus.imem_addr  = addr;
        bus.imem_rmask = 4'hF;
        for (int k = 1; k <= int'(ILAT); k++) begin
            tick();
            if (k < int'(ILAT)) chk({tag, "_early"}, 32'(bus.imem_resp), 32'd0);
        end
        chk({tag, "_resp"}, 32'(bus.imem_resp), 32'd1);
        chk({tag, "_rdata"}, bus.imem_rdata, exp);
        bus.imem_rmask = '0;
        tick();
        chk({tag, "_pulse"}, 32'(bus.imem_resp), 32'd0);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_iresp",  32'(bus.imem_resp), 32'd0);
        chk("rst_dresp",  32'(bus.dmem_resp), 32'd0);
        chk("rst_irdata", bus.imem_rdata, 32'd0);
        chk("rst_drdata", bus.dmem_rdata, 32'd0);
        rst = 1'b0;
        tick();

        // Write then read back.
        dmem_op("wr10", 32'h10, 4'h0, 4'hF, 32'hDEADBEEF, 32'h0);
        dmem_op("rd10", 32'h10, 4'hF, 4'h0, 32'h0, 32'hDEADBEEF);

        // Byte-lane write, read through imem.
        dmem_op("wr10b", 32'h10, 4'h0, 4'hF, 32'h11223344, 32'h0);
        dmem_op("wrbyte", 32'h12, 4'h0, 4'b0100, 32'h00AA0000, 32'h0);
        imem_op("irdbyte", 32'h10, 32'h11AA3344);

        // Same-cycle imem and dmem reads: independent latencies.
        bus.imem_addr  = 32'h10;
        bus.imem_rmask = 4'hF;
        bus.dmem_addr  = 32'h13;
        bus.dmem_rmask = 4'hF;
        tick();
        chk("par_c1_i", 32'(bus.imem_resp), 32'd0);
        chk("par_c1_d", 32'(bus.dmem_resp), 32'd0);
        tick();
        chk("par_c2_i", 32'(bus.imem_resp), 32'd1);
        chk("par_c2_d", 32'(bus.dmem_resp), 32'd0);
        chk("par_c2_irdata", bus.imem_rdata, 32'h11AA3344);
        bus.imem_rmask = '0;
        tick();
        chk("par_c3_i", 32'(bus.imem_resp), 32'd0);
        chk("par_c3_d", 32'(bus.dmem_resp), 32'd1);
        chk("par_c3_drdata", bus.dmem_rdata, 32'h11AA3344);
        bus.dmem_rmask = '0;
        tick();
        chk("par_c4_d", 32'(bus.dmem_resp), 32'd0);

        // Held imem request: pulses at C+2, C+5, C+8; the acceptance in
        // the IDLE cycle C+9 completes at C+11 after the request is dropped.
        bus.imem_addr  = 32'h10;
        bus.imem_rmask = 4'hF;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("held_k%0d", k), 32'(bus.imem_resp),
                (k == 2 || k == 5 || k == 8 || k == 11) ? 32'd1 : 32'd0);
            if (k == 10) bus.imem_rmask = '0;
        end

        // Wrap and cross-port collision on word 0.
        dmem_op("wr0", 32'h0, 4'h0, 4'hF, 32'hCAFEF00D, 32'h0);
        bus.imem_addr  = 32'h0;
        bus.imem_rmask = 4'hF;
        bus.dmem_addr  = 32'h1000;
        bus.dmem_wmask = 4'hF;
        bus.dmem_wdata = 32'h12345678;
        tick();
        tick();
        chk("col_iresp", 32'(bus.imem_resp), 32'd1);
        chk("col_irdata", bus.imem_rdata, 32'hCAFEF00D);
        bus.imem_rmask = '0;
        tick();
        chk("col_dresp", 32'(bus.dmem_resp), 32'd1);
        chk("col_drdata", bus.dmem_rdata, 32'h0);
        bus.dmem_wmask = '0;
        tick();
        imem_op("wrapread", 32'h0, 32'h12345678);

        // Read-modify-write request returns the pre-write word.
        dmem_op("wr20", 32'h20, 4'h0, 4'hF, 32'hA5A5A5A5, 32'h0);
        dmem_op("rmw20", 32'h20, 4'hF, 4'hF, 32'h5A5A5A5A, 32'hA5A5A5A5);
        dmem_op("rd20", 32'h20, 4'hF, 4'h0, 32'h0, 32'h5A5A5A5A);

        // Reset mid-flight: accepted read is dropped, no resp.
        bus.dmem_addr  = 32'h10;
        bus.dmem_rmask = 4'hF;
        tick();                      // now C+1, accepted
        rst = 1'b1;
        bus.dmem_rmask = '0;
        tick();                      // C+2, reset applied
        rst = 1'b0;
        chk("rmid_c2_dresp", 32'(bus.dmem_resp), 32'd0);
        chk("rmid_drdata", bus.dmem_rdata, 32'd0);
        chk("rmid_irdata", bus.imem_rdata, 32'd0);
        tick();                      // C+3
        chk("rmid_c3_dresp", 32'(bus.dmem_resp), 32'd0);
        dmem_op("rmid_new", 32'h10, 4'hF, 4'h0, 32'h0, 32'h11AA3344);

        // Request seen under reset is not accepted and does not write.
        dmem_op("wr30", 32'h30, 4'h0, 4'hF, 32'h01020304, 32'h0);
        rst = 1'b1;
        bus.dmem_addr  = 32'h30;
        bus.dmem_wmask = 4'hF;
        bus.dmem_wdata = 32'hFFFFFFFF;
        tick();
        rst = 1'b0;
        bus.dmem_wmask = '0;
        tick();
        chk("rstreq_dresp", 32'(bus.dmem_resp), 32'd0);
        tick();
        chk("rstreq_dresp2", 32'(bus.dmem_resp), 32'd0);
        dmem_op("rd30", 32'h30, 4'hF, 4'h0, 32'h0, 32'h01020304);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
